// File: rtl/lsu.sv
// lsu: byte/half/word load-store unit driving data RAM port 1 with byte address + lane mask.
// Optional macro LSU_MISALIGN_EN: misaligned half/word accesses are split across two words.
module lsu #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
    output logic                  o_ram_rd_en,
    output logic [3:0]            o_ram_rd_mask,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
    output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
    output logic                  o_ram_wr_en,
    output logic [3:0]            o_ram_wr_mask,
    output logic [DATA_WIDTH-1:0] o_ram_wr_data
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t                  state_q;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
`ifdef LSU_MISALIGN_EN
    logic [DATA_WIDTH-1:0]   word0_q;
    logic [ADDR_WIDTH-1:0]   next_waddr;
`endif

    logic                    rsp_valid_q, rsp_err_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, wr_addr_q;
    logic                    rd_en_q, wr_en_q;
    logic [3:0]              rd_mask_q, wr_mask_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;

    logic                    req_illegal;
    logic [ADDR_WIDTH-1:0]   req_waddr;

    // Lane mask of the access shifted to its byte offset; hi selects the second word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off,
                                             input logic hi);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'b0000_0001;
            2'd1:    m = 8'b0000_0011;
            default: m = 8'b0000_1111;
        endcase
        m = m << off;
        return hi ? m[7:4] : m[3:0];
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] wdata, input logic [1:0] off,
                                              input logic hi);
        logic [63:0] d;
        d = {32'd0, wdata} << {off, 3'b000};
        return hi ? d[63:32] : d[31:0];
    endfunction

    function automatic logic [31:0] extract(input logic [63:0] words, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
        logic [31:0] s;
        logic [31:0] r;
        s = 32'(words >> {off, 3'b000});
        case (size)
            2'd0:    r = uns ? {24'd0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'd1:    r = uns ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_EN
    assign req_illegal = (i_req_size == 2'd3);
    assign next_waddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
`else
    assign req_illegal = (i_req_size == 2'd3)
                       || (i_req_size == 2'd1 && i_req_addr[0])
                       || (i_req_size == 2'd2 && i_req_addr[1:0] != 2'b00);
`endif
    assign req_waddr = {i_req_addr[ADDR_WIDTH-1:2], 2'b00};

    // Load result formed from the word(s) arriving this cycle so the response is registered.
    always_comb begin
        rsp_rdata_d = '0;
        if (!we_q) begin
`ifdef LSU_MISALIGN_EN
            if (state_q == ACC1)
                rsp_rdata_d = extract({i_ram_rd_data, word0_q}, addr_q[1:0], size_q, uns_q);
            else
                rsp_rdata_d = extract({32'd0, i_ram_rd_data}, addr_q[1:0], size_q, uns_q);
`else
            rsp_rdata_d = extract({32'd0, i_ram_rd_data}, addr_q[1:0], size_q, uns_q);
`endif
        end
    end

    // Request fields and first load word carry no reset; the FSM qualifies their use.
    always_ff @(posedge i_clk) begin
        if (state_q == IDLE && i_req_valid) begin
            we_q    <= i_req_we;
            size_q  <= i_req_size;
            uns_q   <= i_req_unsigned;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
        end
`ifdef LSU_MISALIGN_EN
        if (state_q == ACC0)
            word0_q <= i_ram_rd_data;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_mask_q   <= '0;
            wr_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_mask_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_mask_q   <= '0;
            wr_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_mask_q   <= '0;
            wr_data_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (i_req_valid) begin
                        if (req_illegal) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q <= ACC0;
                            if (i_req_we) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= req_waddr;
                                wr_mask_q <= lane_mask(i_req_size, i_req_addr[1:0], 1'b0);
                                wr_data_q <= lane_data(i_req_wdata, i_req_addr[1:0], 1'b0);
                            end else begin
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= req_waddr;
                                rd_mask_q <= lane_mask(i_req_size, i_req_addr[1:0], 1'b0);
                            end
                        end
                    end
                end
                ACC0: begin
`ifdef LSU_MISALIGN_EN
                    if (lane_mask(size_q, addr_q[1:0], 1'b1) != 4'd0) begin
                        state_q <= ACC1;
                        if (we_q) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= next_waddr;
                            wr_mask_q <= lane_mask(size_q, addr_q[1:0], 1'b1);
                            wr_data_q <= lane_data(wdata_q, addr_q[1:0], 1'b1);
                        end else begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= next_waddr;
                            rd_mask_q <= lane_mask(size_q, addr_q[1:0], 1'b1);
                        end
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                    end
`else
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rsp_rdata_d;
`endif
                end
                ACC1: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rsp_rdata_d;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready   = (state_q == IDLE) & ~i_rst;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_ram_rd_addr = rd_addr_q;
    assign o_ram_rd_en   = rd_en_q;
    assign o_ram_rd_mask = rd_mask_q;
    assign o_ram_wr_addr = wr_addr_q;
    assign o_ram_wr_en   = wr_en_q;
    assign o_ram_wr_mask = wr_mask_q;
    assign o_ram_wr_data = wr_data_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a byte-lane RAM model on port 1.
// Split-access vectors are compiled in only when LSU_MISALIGN_EN is defined.
module tb_lsu;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] ram_rd_addr, ram_wr_addr;
    logic          ram_rd_en, ram_wr_en;
    logic [3:0]    ram_rd_mask, ram_wr_mask;
    logic [31:0]   ram_rd_data, ram_wr_data;

    int checks = 0;
    int errors = 0;

    // Values captured by req(): latency and the RAM signals seen in the two access cycles.
    int            lat;
    logic          rd_seen;
    logic [31:0]   got_rdata;
    logic          got_err;
    logic [AW-1:0] a0_rd_addr, a0_wr_addr, a1_wr_addr;
    logic [3:0]    a0_rd_mask, a0_wr_mask, a1_wr_mask;
    logic [31:0]   a0_wr_data, a1_wr_data;

    always #5 clk = ~clk;

    lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_size(req_size), .i_req_unsigned(req_unsigned), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_ram_rd_addr(ram_rd_addr), .o_ram_rd_en(ram_rd_en), .o_ram_rd_mask(ram_rd_mask),
        .i_ram_rd_data(ram_rd_data),
        .o_ram_wr_addr(ram_wr_addr), .o_ram_wr_en(ram_wr_en), .o_ram_wr_mask(ram_wr_mask),
        .o_ram_wr_data(ram_wr_data)
    );

    logic [7:0] mem [0:255];
    logic [7:0] ra;

    always_comb begin
        ram_rd_data = '0;
        ra = '0;
        if (ram_rd_en) begin
            for (int i = 0; i < 4; i++) begin
                ra = ram_rd_addr + 8'(i);
                if (ram_rd_mask[i]) ram_rd_data[8*i +: 8] = mem[ra];
            end
        end
    end

    always @(posedge clk) begin
        if (ram_wr_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_wr_mask[i]) mem[ram_wr_addr + 8'(i)] <= ram_wr_data[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [AW-1:0] a, input logic [31:0] wd);
        logic got;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 99; rd_seen = 1'b0; got = 1'b0;
        got_rdata = 32'hxxxx_xxxx; got_err = 1'bx;
        for (int c = 1; c <= 6 && !got; c++) begin
            if (ram_rd_en) rd_seen = 1'b1;
            if (c == 1) begin
                a0_rd_addr = ram_rd_addr; a0_rd_mask = ram_rd_mask;
                a0_wr_addr = ram_wr_addr; a0_wr_mask = ram_wr_mask; a0_wr_data = ram_wr_data;
            end
            if (c == 2) begin
                a1_wr_addr = ram_wr_addr; a1_wr_mask = ram_wr_mask; a1_wr_data = ram_wr_data;
            end
            if (rsp_valid) begin
                got = 1'b1; lat = c; got_rdata = rsp_rdata; got_err = rsp_err;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset state
        #12;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_wr_mask", 32'(ram_wr_mask), 32'd0);
        #6 rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", 32'(req_ready), 32'd1);

        // Word store / load
        req(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF);
        chk("sw_wr_mask", 32'(a0_wr_mask), 32'hF);
        chk("sw_wr_data", a0_wr_data, 32'hDEADBEEF);
        chk("sw_wr_addr", 32'(a0_wr_addr), 32'h10);
        chk("sw_rdata", got_rdata, 32'd0);
        chk("sw_err", 32'(got_err), 32'd0);
        chk("sw_lat", 32'(lat), 32'd2);
        req(1'b0, 2'd2, 1'b0, 8'h10, 32'd0);
        chk("lw_rd_mask", 32'(a0_rd_mask), 32'hF);
        chk("lw_rdata", got_rdata, 32'hDEADBEEF);
        chk("lw_err", 32'(got_err), 32'd0);
        chk("lw_lat", 32'(lat), 32'd2);

        // Byte store to lane 3, signed and unsigned load back
        req(1'b1, 2'd0, 1'b0, 8'h13, 32'h00000080);
        chk("sb_wr_mask", 32'(a0_wr_mask), 32'h8);
        chk("sb_wr_data", a0_wr_data, 32'h80000000);
        req(1'b0, 2'd0, 1'b0, 8'h13, 32'd0);
        chk("lb_rd_mask", 32'(a0_rd_mask), 32'h8);
        chk("lb_rdata", got_rdata, 32'hFFFFFF80);
        req(1'b0, 2'd0, 1'b1, 8'h13, 32'd0);
        chk("lbu_rdata", got_rdata, 32'h00000080);

        // Halfword loads from word 0x20 = 0x80011234
        req(1'b1, 2'd2, 1'b0, 8'h20, 32'h80011234);
        req(1'b0, 2'd1, 1'b0, 8'h22, 32'd0);
        chk("lh_rd_mask", 32'(a0_rd_mask), 32'hC);
        chk("lh_rdata", got_rdata, 32'hFFFF8001);
        req(1'b0, 2'd1, 1'b1, 8'h20, 32'd0);
        chk("lhu_rdata", got_rdata, 32'h00001234);
        req(1'b0, 2'd0, 1'b1, 8'h21, 32'd0);
        chk("lbu1_rdata", got_rdata, 32'h00000012);

        // Halfword store keeps only its two lanes
        req(1'b1, 2'd1, 1'b0, 8'h16, 32'h1234ABCD);
        chk("sh_wr_mask", 32'(a0_wr_mask), 32'hC);
        chk("sh_wr_data", a0_wr_data, 32'hABCD0000);
        req(1'b0, 2'd2, 1'b0, 8'h14, 32'd0);
        chk("sh_readback", got_rdata & 32'hFFFF0000, 32'hABCD0000);

        // size = 3 is rejected in every build
        req(1'b0, 2'd3, 1'b0, 8'h10, 32'd0);
        chk("sz3_err", 32'(got_err), 32'd1);
        chk("sz3_rdata", got_rdata, 32'd0);
        chk("sz3_rd_seen", 32'(rd_seen), 32'd0);
        chk("sz3_lat", 32'(lat), 32'd1);

`ifdef LSU_MISALIGN_EN
        // Split word store wrapping past the top of memory
        req(1'b1, 2'd2, 1'b0, 8'hFE, 32'hAABBCCDD);
        chk("split_a0_addr", 32'(a0_wr_addr), 32'hFC);
        chk("split_a0_mask", 32'(a0_wr_mask), 32'hC);
        chk("split_a0_data", a0_wr_data, 32'hCCDD0000);
        chk("split_a1_addr", 32'(a1_wr_addr), 32'h00);
        chk("split_a1_mask", 32'(a1_wr_mask), 32'h3);
        chk("split_a1_data", a1_wr_data, 32'h0000AABB);
        chk("split_st_lat", 32'(lat), 32'd3);
        req(1'b0, 2'd2, 1'b0, 8'hFE, 32'd0);
        chk("split_ld_rdata", got_rdata, 32'hAABBCCDD);
        chk("split_ld_lat", 32'(lat), 32'd3);
`else
        // Misaligned accesses are errors without a RAM access
        req(1'b0, 2'd2, 1'b0, 8'h01, 32'd0);
        chk("mis_lw_err", 32'(got_err), 32'd1);
        chk("mis_lw_rdata", got_rdata, 32'd0);
        chk("mis_lw_rd_seen", 32'(rd_seen), 32'd0);
        chk("mis_lw_lat", 32'(lat), 32'd1);
        req(1'b0, 2'd1, 1'b0, 8'h23, 32'd0);
        chk("mis_lh_err", 32'(got_err), 32'd1);
`endif

        // Reset asserted during ACC0 of a store
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 8'h30; req_wdata = 32'h11111111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_wr_en_pre", 32'(ram_wr_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_wr_en", 32'(ram_wr_en), 32'd0);
        chk("mid_wr_mask", 32'(ram_wr_mask), 32'd0);
        chk("mid_wr_data", ram_wr_data, 32'd0);
        chk("mid_ready", 32'(req_ready), 32'd0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        req(1'b0, 2'd2, 1'b0, 8'h10, 32'd0);
        chk("post_rst_rdata", got_rdata, 32'h80ADBEEF);
        chk("post_rst_lat", 32'(lat), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly upstream of the data RAM.
- Accepts byte/half/word load and store requests from the core over a valid/ready handshake.
- Converts each request into the RAM's byte-address + 4-bit lane-mask access on its port 1 read and write ports; RAM port 2 stays with instruction fetch.
- Aligns store data into lanes, and extracts plus sign/zero-extends load data.

Parameters:
- ADDR_WIDTH, 8, byte-address width; must match the RAM's ADDR_WIDTH.
- DATA_WIDTH, 32, word width; only 32 is supported.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  unit can accept a request.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- i_req_addr  in  ADDR_WIDTH  byte address.
- i_req_wdata  in  32  store data, right-justified.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  32  load result; 0 for stores and errors.
- o_rsp_err  out  1  request rejected; no RAM access made.
- o_ram_rd_addr  out  ADDR_WIDTH  to RAM i_rd1_addr.
- o_ram_rd_en  out  1  to RAM i_rd1_en.
- o_ram_rd_mask  out  4  to RAM i_rd1_mask.
- i_ram_rd_data  in  32  from RAM o_rd1_data: combinational, masked, lanes in place.
- o_ram_wr_addr  out  ADDR_WIDTH  to RAM i_wr_addr.
- o_ram_wr_en  out  1  to RAM i_wr_en.
- o_ram_wr_mask  out  4  to RAM i_wr_mask.
- o_ram_wr_data  out  32  to RAM i_wr_data, lane-aligned.

Behaviour:
- Reset values:
  - State IDLE.
  - o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0.
  - All RAM enables, masks, addresses and data = 0.
  - o_req_ready = (state==IDLE) & ~i_rst, so it is 0 while reset is held.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - ready = 1.
  - On valid & ready, latch we/size/unsigned/addr/wdata.
  - Go to RESP with err=1 if the request is illegal (see Optional Feature); otherwise go to ACC0.
- ACC0:
  - Drive word address {addr[ADDR_WIDTH-1:2], 2'b00} with lane mask m0 = (smask << off)[3:0].
  - off = addr[1:0]; smask = 4'b0001 for byte, 4'b0011 for half, 4'b1111 for word.
  - Load: rd_en = 1, and capture i_ram_rd_data into word0 at the clock edge.
  - Store: wr_en = 1, wr_data = (wdata << 8*off)[31:0]. The write commits at the end of this cycle.
  - Go to ACC1 if (smask << off)[7:4] != 0; otherwise go to RESP.
- ACC1 (split access only):
  - Word address = the ACC0 word address + 4, modulo 2^ADDR_WIDTH (wraps at top of memory).
  - Mask m1 = (smask << off)[7:4].
  - Store data = (wdata << 8*off)[63:32].
  - Load captures word1. Go to RESP.
- RESP:
  - o_rsp_valid = 1 for exactly one cycle, then return to IDLE.
  - Load result = ({word1, word0} >> 8*off), truncated to size, then sign- or zero-extended to 32.
  - Store or error result: rdata = 0.
- Enables: rd_en/wr_en are 0 in IDLE and RESP, and never both 1 in the same cycle.
- Response latency from the accept edge: aligned access = rsp in 2nd following cycle; split access = 3rd; error = 1st.
- ready is 0 from ACC0 through RESP; only one request is outstanding at a time.
- Reset mid-operation:
  - Async return to IDLE; the enables drop immediately.
  - A split store may leave ACC0's word written and ACC1's word unwritten; there is no rollback.

Optional Feature:
- Macro: LSU_MISALIGN_EN.
- Defined:
  - Misaligned half/word accesses are legal and split across two words via ACC1.
  - size = 3 is the only illegal request.
- Undefined:
  - ACC1 is removed.
  - Illegal requests: half with addr[0] = 1, word with addr[1:0] != 0, and size = 3.
  - These give a one-cycle err response with no RAM enable asserted.

Test Plan:
- Store word 0xDEADBEEF to addr 0x10, then load word from 0x10 -> wr_mask 4'b1111, rsp_rdata = 0xDEADBEEF, err = 0, rsp 2 cycles after accept.
- Store byte 0x80 to addr 0x13, then load signed byte from 0x13 -> wr_mask 4'b1000, wr_data = 0x80000000, rdata = 0xFFFFFF80; unsigned load gives 0x00000080.
- Load signed half from 0x22, where word 0x20 = 0x8001_1234 -> rd_mask 4'b1100, rdata = 0xFFFF8001.
- With macro: store word 0xAABBCCDD to addr 0xFE (ADDR_WIDTH = 8) -> ACC0 writes word 0xFC with mask 1100 and data 0xCCDD0000; ACC1 writes word 0x00 (wrapped) with mask 0011 and data 0x0000AABB; load-back gives 0xAABBCCDD, rsp 3 cycles after accept.
- Without macro: load word from 0x01 -> o_rsp_err = 1, rdata = 0, rd_en never asserted, rsp 1 cycle after accept. size = 3 gives err in both builds.
- Assert i_rst during ACC0 of a store -> outputs return to reset values asynchronously; ready = 1 the cycle after release; the next request completes normally.
